// File: rtl/uart_block_assembler.sv
// Packs consecutive UART bytes into one BLOCK_BYTES*8-bit block and hands it over a valid/ready handshake.
// Optional idle-timeout for partial blocks is enabled by defining UART_BLOCK_ASSEMBLER_TIMEOUT_EN.
module uart_block_assembler #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int BAUDRATE      = 115_200,
    parameter int BLOCK_BYTES   = 16,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [7:0]                         byte_in,
    input  logic                               byte_valid,
    output logic [BLOCK_BYTES*8-1:0]           block_out,
    output logic                               block_valid,
    input  logic                               block_ready,
    output logic [$clog2(BLOCK_BYTES+1)-1:0]   byte_count,
    output logic                               overrun_err,
    output logic                               timeout_err
);

    localparam int W  = BLOCK_BYTES * 8;
    localparam int CW = $clog2(BLOCK_BYTES + 1);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_block;
    logic [CW-1:0]   r_count;
    logic            r_valid;
    logic            r_overrun;
    logic            w_last;
    logic            w_tmo;

    assign w_last = (r_count == CW'(BLOCK_BYTES - 1));

`ifdef UART_BLOCK_ASSEMBLER_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUDRATE);
    localparam int TCW            = $clog2(TIMEOUT_CYCLES);

    logic [TCW-1:0]  r_tcnt;
    logic            r_timeout;

    // A byte arriving in the would-be timeout cycle wins, hence the !byte_valid term.
    assign w_tmo = (r_state == S_COLLECT) && !byte_valid && (r_count != '0) &&
                   (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));

    // Idle counter: only runs while a partial block waits for more bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo;
            if ((r_state != S_COLLECT) || byte_valid || (r_count == '0) || w_tmo) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + TCW'(1);
            end
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_tmo       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Collect/hold FSM with all block outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_COLLECT;
            r_block   <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (byte_valid) begin
                        r_block <= {r_block[W-9:0], byte_in};
                        r_count <= r_count + CW'(1);
                        if (w_last) begin
                            r_state <= S_HOLD;
                            r_valid <= 1'b1;
                        end
                    end else if (w_tmo) begin
                        r_block <= '0;
                        r_count <= '0;
                    end
                end
                S_HOLD: begin
                    if (block_ready) begin
                        // A byte coincident with the transfer becomes byte 0 of the next block.
                        r_valid <= 1'b0;
                        r_state <= S_COLLECT;
                        if (byte_valid) begin
                            r_block <= {r_block[W-9:0], byte_in};
                            r_count <= CW'(1);
                        end else begin
                            r_count <= '0;
                        end
                    end else if (byte_valid) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                    r_valid <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign block_out   = r_block;
    assign block_valid = r_valid;
    assign byte_count  = r_count;
    assign overrun_err = r_overrun;

endmodule

// File: tb/tb_uart_block_assembler.sv
// Directed bench for uart_block_assembler: table-driven first block plus hand-written corner sequences.
module tb_uart_block_assembler;

    logic         clk;
    logic         rst_n;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic [127:0] block_out;
    logic         block_valid;
    logic         block_ready;
    logic [4:0]   byte_count;
    logic         overrun_err;
    logic         timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_block_assembler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .byte_count  (byte_count),
        .overrun_err (overrun_err),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         bv;
        logic [7:0]   b;
        logic         rdy;
        logic         e_valid;
        logic [4:0]   e_cnt;
        logic         e_ovr;
        logic [7:0]   e_lo;
        logic         chk_blk;
        logic [127:0] e_blk;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic step(input logic bv, input logic [7:0] b, input logic rdy);
        byte_valid  = bv;
        byte_in     = b;
        block_ready = rdy;
        @(posedge clk);
        #1;
        byte_valid  = 1'b0;
        block_ready = 1'b0;
    endtask

    initial begin
        logic err_seen;
        logic hold_ok;
        int   k;
        int   hit;

        rst_n       = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        block_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {127'd0, block_valid}, 128'd0);
        chk("reset_count", {123'd0, byte_count}, 128'd0);
        chk("reset_block", block_out, 128'd0);
        chk("reset_errs", {126'd0, overrun_err, timeout_err}, 128'd0);
        rst_n = 1'b1;

        // Bytes 0x00..0x0F with block_ready held high; ready is ignored until valid.
        for (int i = 0; i < 16; i++) begin
            vecs[i].bv      = 1'b1;
            vecs[i].b       = 8'(i);
            vecs[i].rdy     = 1'b1;
            vecs[i].e_valid = (i == 15) ? 1'b1 : 1'b0;
            vecs[i].e_cnt   = 5'(i + 1);
            vecs[i].e_ovr   = 1'b0;
            vecs[i].e_lo    = 8'(i);
            vecs[i].chk_blk = (i == 15) ? 1'b1 : 1'b0;
            vecs[i].e_blk   = 128'h000102030405060708090A0B0C0D0E0F;
        end
        for (int i = 16; i < 18; i++) begin
            vecs[i].bv      = 1'b0;
            vecs[i].b       = 8'h00;
            vecs[i].rdy     = 1'b1;
            vecs[i].e_valid = 1'b0;
            vecs[i].e_cnt   = 5'd0;
            vecs[i].e_ovr   = 1'b0;
            vecs[i].e_lo    = 8'h0F;
            vecs[i].chk_blk = 1'b0;
            vecs[i].e_blk   = 128'd0;
        end

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].bv, vecs[i].b, vecs[i].rdy);
            chk($sformatf("tab%0d_valid", i), {127'd0, block_valid}, {127'd0, vecs[i].e_valid});
            chk($sformatf("tab%0d_count", i), {123'd0, byte_count}, {123'd0, vecs[i].e_cnt});
            chk($sformatf("tab%0d_ovr", i), {127'd0, overrun_err}, {127'd0, vecs[i].e_ovr});
            chk($sformatf("tab%0d_lo", i), {120'd0, block_out[7:0]}, {120'd0, vecs[i].e_lo});
            if (vecs[i].chk_blk) begin
                chk($sformatf("tab%0d_block", i), block_out, vecs[i].e_blk);
            end
        end

        // Overrun: block pending, consumer stalls 50 cycles, then a stray byte arrives.
        for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
        hold_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (block_valid !== 1'b1 || byte_count !== 5'd16 || overrun_err !== 1'b0) hold_ok = 1'b0;
        end
        chk("stall_hold", {127'd0, hold_ok}, 128'd1);
        step(1'b1, 8'hAA, 1'b0);
        chk("ovr_pulse", {127'd0, overrun_err}, 128'd1);
        chk("ovr_block", block_out, 128'h202122232425262728292A2B2C2D2E2F);
        chk("ovr_count", {123'd0, byte_count}, 128'd16);
        chk("ovr_valid", {127'd0, block_valid}, 128'd1);
        step(1'b0, 8'h00, 1'b0);
        chk("ovr_single", {127'd0, overrun_err}, 128'd0);
        chk("ovr_still_valid", {127'd0, block_valid}, 128'd1);

        // Byte strobed in the same cycle as the transfer starts the next block.
        step(1'b1, 8'h55, 1'b1);
        chk("xfer_byte_valid", {127'd0, block_valid}, 128'd0);
        chk("xfer_byte_count", {123'd0, byte_count}, 128'd1);
        chk("xfer_byte_lo", {120'd0, block_out[7:0]}, 128'h55);
        chk("xfer_byte_ovr", {127'd0, overrun_err}, 128'd0);

        // Partial block of 7 bytes, one-cycle reset, then a clean block.
        for (int i = 0; i < 6; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
        chk("partial_count", {123'd0, byte_count}, 128'd7);
        rst_n = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        chk("rst_count", {123'd0, byte_count}, 128'd0);
        chk("rst_block", block_out, 128'd0);
        err_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b0);
            if (overrun_err !== 1'b0 || timeout_err !== 1'b0) err_seen = 1'b1;
        end
        chk("post_rst_block", block_out, 128'h101112131415161718191A1B1C1D1E1F);
        chk("post_rst_valid", {127'd0, block_valid}, 128'd1);
        chk("post_rst_noerr", {127'd0, err_seen}, 128'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_xfer", {123'd0, byte_count}, 128'd0);

`ifdef UART_BLOCK_ASSEMBLER_TIMEOUT_EN
        for (int i = 0; i < 5; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0);
        hit = 0;
        k   = 0;
        while (hit == 0 && k < 40000) begin
            step(1'b0, 8'h00, 1'b0);
            k++;
            if (timeout_err === 1'b1) hit = k;
        end
        chk("tmo_latency", 128'(hit), 128'd34720);
        chk("tmo_count", {123'd0, byte_count}, 128'd0);
        chk("tmo_block", block_out, 128'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("tmo_single", {127'd0, timeout_err}, 128'd0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'hF0 + 8'(i), 1'b0);
        chk("tmo_next_block", block_out, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        chk("tmo_next_valid", {127'd0, block_valid}, 128'd1);
`else
        for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
        err_seen = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (timeout_err !== 1'b0) err_seen = 1'b1;
        end
        chk("notmo_err", {127'd0, err_seen}, 128'd0);
        chk("notmo_count", {123'd0, byte_count}, 128'd5);
        for (int i = 5; i < 16; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
        chk("notmo_block", block_out, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        chk("notmo_valid", {127'd0, block_valid}, 128'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
